// File: rtl/lcd_timing_driver.sv
// RGB-interface LCD timing generator: free-running h/v counters decoded into
// HS/VS/DE, a one-clock-early pixel request, and gating of the returned colour.
module lcd_timing_driver #(
  parameter logic [10:0] H_SYNC  = 11'd41,
  parameter logic [10:0] H_BACK  = 11'd2,
  parameter logic [10:0] H_DISP  = 11'd480,
  parameter logic [10:0] H_FRONT = 11'd2,
  parameter logic [10:0] V_SYNC  = 11'd10,
  parameter logic [10:0] V_BACK  = 11'd2,
  parameter logic [10:0] V_DISP  = 11'd272,
  parameter logic [10:0] V_FRONT = 11'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [15:0] lcd_rgb,
  output logic        lcd_bl,
  output logic        lcd_rst,
  output logic        frame_start
);

  localparam logic [10:0] H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam logic [10:0] V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [10:0] H_ACT_S = H_SYNC + H_BACK;
  localparam logic [10:0] H_ACT_E = H_ACT_S + H_DISP;
  localparam logic [10:0] H_REQ_S = H_ACT_S - 11'd1;
  localparam logic [10:0] H_REQ_E = H_ACT_E - 11'd1;
  localparam logic [10:0] V_ACT_S = V_SYNC + V_BACK;
  localparam logic [10:0] V_ACT_E = V_ACT_S + V_DISP;

  logic [10:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic        r_bl;
  logic        r_rst;

  logic        w_h_act;
  logic        w_v_act;
  logic        w_data_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_TOTAL - 11'd1) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_TOTAL - 11'd1) ? '0 : r_v_cnt + 11'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 11'd1;
    end
  end

  // Panel power-up controls: released on the first edge after reset and held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bl  <= 1'b0;
      r_rst <= 1'b0;
    end else begin
      r_bl  <= 1'b1;
      r_rst <= 1'b1;
    end
  end

  assign w_h_act    = (r_h_cnt >= H_ACT_S) && (r_h_cnt < H_ACT_E);
  assign w_v_act    = (r_v_cnt >= V_ACT_S) && (r_v_cnt < V_ACT_E);
  // Request window leads DE by one clock to cover the colour generator's register.
  assign w_data_req = w_v_act && (r_h_cnt >= H_REQ_S) && (r_h_cnt < H_REQ_E);

  assign lcd_hs      = (r_h_cnt >= H_SYNC);
  assign lcd_vs      = (r_v_cnt >= V_SYNC);
  assign lcd_de      = w_h_act && w_v_act;
  assign pixel_xpos  = w_data_req ? (r_h_cnt - H_REQ_S) : 11'd0;
  assign pixel_ypos  = w_data_req ? (r_v_cnt - V_ACT_S) : 11'd0;
  assign lcd_rgb     = lcd_de ? pixel_data : 16'h0000;
  assign lcd_bl      = r_bl;
  assign lcd_rst     = r_rst;
  assign frame_start = rst_n && (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Bench for lcd_timing_driver: a default-size and a shrunken instance run side by
// side against a cycle-count reference model, with randomized returned colour.
module tb_lcd_timing_driver;

  typedef struct {
    int hs, hb, hd, hf, vs, vb, vd, vf;
  } prm_t;

  typedef struct {
    bit hs, vs, de, fs;
    int xpos, ypos, col;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] a_pd, b_pd;
  logic [10:0] a_xp, a_yp, b_xp, b_yp;
  logic        a_hs, a_vs, a_de, a_bl, a_rs, a_fs;
  logic        b_hs, b_vs, b_de, b_bl, b_rs, b_fs;
  logic [15:0] a_rgb, b_rgb;

  lcd_timing_driver dut_a (
    .clk(clk), .rst_n(rst_n), .pixel_data(a_pd),
    .pixel_xpos(a_xp), .pixel_ypos(a_yp),
    .lcd_hs(a_hs), .lcd_vs(a_vs), .lcd_de(a_de), .lcd_rgb(a_rgb),
    .lcd_bl(a_bl), .lcd_rst(a_rs), .frame_start(a_fs)
  );

  lcd_timing_driver #(
    .H_SYNC(11'd5), .H_BACK(11'd3), .H_DISP(11'd20), .H_FRONT(11'd4),
    .V_SYNC(11'd3), .V_BACK(11'd2), .V_DISP(11'd6), .V_FRONT(11'd2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .pixel_data(b_pd),
    .pixel_xpos(b_xp), .pixel_ypos(b_yp),
    .lcd_hs(b_hs), .lcd_vs(b_vs), .lcd_de(b_de), .lcd_rgb(b_rgb),
    .lcd_bl(b_bl), .lcd_rst(b_rs), .frame_start(b_fs)
  );

  int n_cmp = 0;
  int n_err = 0;
  prm_t pa, pb;
  int t_a, t_b;
  logic [4:0] tag_a, tag_b;
  int first_de_a;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Position within the frame follows purely from clocks elapsed since reset release.
  function automatic exp_t model(input int t, input prm_t p);
    exp_t e;
    int ht, vt, h, v, hs0, vs0;
    bit vact, req;
    ht   = p.hs + p.hb + p.hd + p.hf;
    vt   = p.vs + p.vb + p.vd + p.vf;
    h    = t % ht;
    v    = (t / ht) % vt;
    hs0  = p.hs + p.hb;
    vs0  = p.vs + p.vb;
    vact = (v >= vs0) && (v < vs0 + p.vd);
    req  = vact && (h + 1 >= hs0) && (h + 1 < hs0 + p.hd);
    e.hs   = (h >= p.hs);
    e.vs   = (v >= p.vs);
    e.de   = vact && (h >= hs0) && (h < hs0 + p.hd);
    e.fs   = (t % (ht * vt)) == 0;
    e.xpos = req ? h + 1 - hs0 : 0;
    e.ypos = req ? v - vs0 : 0;
    e.col  = h - hs0;
    return e;
  endfunction

  task automatic check_run(input string nm, input prm_t p, input int t, input logic [4:0] tag,
                           input logic hs, input logic vs, input logic de, input logic fs,
                           input logic bl, input logic rs, input logic [10:0] xp,
                           input logic [10:0] yp, input logic [15:0] rgb);
    exp_t e;
    logic [10:0] c;
    e = model(t, p);
    c = 11'(e.col);
    chk({nm, "_hs"}, 32'(hs), 32'(e.hs));
    chk({nm, "_vs"}, 32'(vs), 32'(e.vs));
    chk({nm, "_de"}, 32'(de), 32'(e.de));
    chk({nm, "_frame_start"}, 32'(fs), 32'(e.fs));
    chk({nm, "_xpos"}, 32'(xp), 32'(e.xpos));
    chk({nm, "_ypos"}, 32'(yp), 32'(e.ypos));
    chk({nm, "_bl"}, 32'(bl), 32'(t > 0));
    chk({nm, "_lcd_rst"}, 32'(rs), 32'(t > 0));
    chk({nm, "_rgb"}, 32'(rgb), e.de ? 32'({tag, c}) : 32'h0);
  endtask

  task automatic check_reset(input string nm, input logic hs, input logic vs, input logic de,
                             input logic fs, input logic bl, input logic rs,
                             input logic [10:0] xp, input logic [10:0] yp, input logic [15:0] rgb);
    chk({nm, "_rst_hs"}, 32'(hs), 32'h0);
    chk({nm, "_rst_vs"}, 32'(vs), 32'h0);
    chk({nm, "_rst_de"}, 32'(de), 32'h0);
    chk({nm, "_rst_fs"}, 32'(fs), 32'h0);
    chk({nm, "_rst_bl"}, 32'(bl), 32'h0);
    chk({nm, "_rst_lcdrst"}, 32'(rs), 32'h0);
    chk({nm, "_rst_xpos"}, 32'(xp), 32'h0);
    chk({nm, "_rst_ypos"}, 32'(yp), 32'h0);
    chk({nm, "_rst_rgb"}, 32'(rgb), 32'h0);
  endtask

  function automatic logic [15:0] junk();
    return ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
  endfunction

  task automatic check_both();
    check_run("A", pa, t_a, tag_a, a_hs, a_vs, a_de, a_fs, a_bl, a_rs, a_xp, a_yp, a_rgb);
    check_run("B", pb, t_b, tag_b, b_hs, b_vs, b_de, b_fs, b_bl, b_rs, b_xp, b_yp, b_rgb);
    if (a_de && first_de_a < 0) first_de_a = t_a;
  endtask

  // The colour generator answers each request one clock later; off-window cycles get junk.
  task automatic cycle();
    exp_t na, nb;
    logic [4:0] ta, tb;
    logic [15:0] npa, npb;
    na  = model(t_a + 1, pa);
    nb  = model(t_b + 1, pb);
    ta  = 5'($urandom);
    tb  = 5'($urandom);
    npa = na.de ? {ta, a_xp} : junk();
    npb = nb.de ? {tb, b_xp} : junk();
    @(posedge clk);
    a_pd = npa;
    b_pd = npb;
    tag_a = ta;
    tag_b = tb;
    t_a++;
    t_b++;
    #1 check_both();
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    t_a = 0;
    t_b = 0;
    a_pd = 16'hFFFF;
    b_pd = 16'hFFFF;
    #1 check_both();
  endtask

  initial begin
    pa = '{41, 2, 480, 2, 10, 2, 272, 2};
    pb = '{5, 3, 20, 4, 3, 2, 6, 2};
    a_pd = 16'hFFFF;
    b_pd = 16'hFFFF;
    tag_a = '0;
    tag_b = '0;
    first_de_a = -1;

    repeat (5) @(posedge clk);
    #1 check_reset("A", a_hs, a_vs, a_de, a_fs, a_bl, a_rs, a_xp, a_yp, a_rgb);
    check_reset("B", b_hs, b_vs, b_de, b_fs, b_bl, b_rs, b_xp, b_yp, b_rgb);

    #1 release_reset();
    repeat (100 * 525 + 200) cycle();
    chk("A_de_before_drop", 32'(a_de), 32'h1);

    #1 rst_n = 1'b0;
    #1 check_reset("A", a_hs, a_vs, a_de, a_fs, a_bl, a_rs, a_xp, a_yp, a_rgb);
    check_reset("B", b_hs, b_vs, b_de, b_fs, b_bl, b_rs, b_xp, b_yp, b_rgb);
    repeat (3) @(posedge clk);
    #1 check_reset("A", a_hs, a_vs, a_de, a_fs, a_bl, a_rs, a_xp, a_yp, a_rgb);
    check_reset("B", b_hs, b_vs, b_de, b_fs, b_bl, b_rs, b_xp, b_yp, b_rgb);

    first_de_a = -1;
    #1 release_reset();
    repeat (12 * 525 + 100) cycle();
    chk("A_first_de_after_reset", 32'(first_de_a), 32'(12 * 525 + 43));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
